// File: rtl/if_stage_pkg.sv
// Shared definitions for the instruction-fetch stage: FSM state encoding,
// PC increment and IF/ID field widths.
package if_stage_pkg;

  localparam int unsigned INSTR_W = 32;
  localparam int unsigned PC_W    = 32;

  // Byte distance between consecutive sequential fetches
  localparam logic [PC_W-1:0] PC_INC = PC_W'(4);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,  // request issued on the memory port
    S_WAIT = 2'd1,  // response pending
    S_HOLD = 2'd2,  // response buffered while the pipeline is stalled
    S_DROP = 2'd3   // stale response (pre-redirect) is being discarded
  } state_t;

endpackage

// File: rtl/if_stage.sv
// Instruction-fetch stage with a single-outstanding-request memory port,
// a one-entry stall buffer and the IF/ID pipeline register.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   pc_write            1 = IF/ID may advance, 0 = stall (PC and IF/ID frozen)
//   flush, redirect_pc  redirect from a later stage; highest priority after rst
//   imem_req_*          fetch request (valid/ready), imem_addr = current PC
//   imem_rsp_*          in-order fetch response, one per accepted request
//   if_id_*             IF/ID register (instr, pc, valid)
//   misalign_err        one-cycle pulse on an unaligned redirect
//                       (only when IF_ALIGN_CHECK_EN is defined)
//
// Build option: define IF_ALIGN_CHECK_EN to force-align redirect targets and
// expose misalign_err.
module if_stage
  import if_stage_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               pc_write,
  input  logic               flush,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic               imem_req_valid,
  input  logic               imem_req_ready,
  output logic [PC_W-1:0]    imem_addr,
  input  logic               imem_rsp_valid,
  input  logic [INSTR_W-1:0] imem_rsp_data,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc,
`ifdef IF_ALIGN_CHECK_EN
  output logic               if_id_valid,
  output logic               misalign_err
`else
  output logic               if_id_valid
`endif
);

  state_t             state_q, state_d;
  logic [PC_W-1:0]    pc_q, pc_d;
  logic [INSTR_W-1:0] instr_d;
  logic [PC_W-1:0]    ipc_d;
  logic               ivalid_d;
  logic [INSTR_W-1:0] hold_data_q, hold_data_d;
  logic               hold_valid_q, hold_valid_d;
  logic [PC_W-1:0]    redirect_tgt;

`ifdef IF_ALIGN_CHECK_EN
  logic mis_d;
  assign redirect_tgt = redirect_pc & ~PC_W'(32'h3);
`else
  assign redirect_tgt = redirect_pc;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_REQ;
    else     state_q <= state_d;
  end

  // Next-state logic; a flush decides whether a response is still owed
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_REQ: begin
        if (flush)               state_d = imem_req_ready ? S_DROP : S_REQ;
        else if (imem_req_ready) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (flush)               state_d = imem_rsp_valid ? S_REQ : S_DROP;
        else if (imem_rsp_valid) state_d = pc_write ? S_REQ : S_HOLD;
      end
      S_HOLD: begin
        if (flush || pc_write) state_d = S_REQ;
      end
      S_DROP: begin
        // The owed response retires the drop even if a new flush lands with it
        if (imem_rsp_valid) state_d = S_REQ;
      end
      default: state_d = S_REQ;
    endcase
  end

  // Datapath next values: PC, IF/ID and hold buffer
  always_comb begin
    pc_d         = pc_q;
    instr_d      = if_id_instr;
    ipc_d        = if_id_pc;
    ivalid_d     = if_id_valid;
    hold_data_d  = hold_data_q;
    hold_valid_d = hold_valid_q;
`ifdef IF_ALIGN_CHECK_EN
    mis_d        = 1'b0;
`endif
    if (flush) begin
      ivalid_d     = 1'b0;
      pc_d         = redirect_tgt;
      hold_valid_d = 1'b0;
`ifdef IF_ALIGN_CHECK_EN
      mis_d        = |redirect_pc[1:0];
`endif
    end else begin
      case (state_q)
        S_WAIT: begin
          if (imem_rsp_valid && pc_write) begin
            instr_d  = imem_rsp_data;
            ipc_d    = pc_q;
            ivalid_d = 1'b1;
            pc_d     = pc_q + PC_INC;
          end else if (imem_rsp_valid) begin
            hold_data_d  = imem_rsp_data;
            hold_valid_d = 1'b1;
          end else if (pc_write) begin
            ivalid_d = 1'b0;
          end
        end
        S_HOLD: begin
          if (pc_write) begin
            instr_d      = hold_data_q;
            ipc_d        = pc_q;
            ivalid_d     = hold_valid_q;
            hold_valid_d = 1'b0;
            pc_d         = pc_q + PC_INC;
          end
        end
        default: begin
          // S_REQ / S_DROP: nothing to load, advance inserts a bubble
          if (pc_write) ivalid_d = 1'b0;
        end
      endcase
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q           <= RESET_PC;
      if_id_instr    <= '0;
      if_id_pc       <= '0;
      if_id_valid    <= 1'b0;
      hold_data_q    <= '0;
      hold_valid_q   <= 1'b0;
      imem_req_valid <= 1'b1;
`ifdef IF_ALIGN_CHECK_EN
      misalign_err   <= 1'b0;
`endif
    end else begin
      pc_q           <= pc_d;
      if_id_instr    <= instr_d;
      if_id_pc       <= ipc_d;
      if_id_valid    <= ivalid_d;
      hold_data_q    <= hold_data_d;
      hold_valid_q   <= hold_valid_d;
      imem_req_valid <= (state_d == S_REQ);
`ifdef IF_ALIGN_CHECK_EN
      misalign_err   <= mis_d;
`endif
    end
  end

  assign imem_addr = pc_q;

endmodule
